// File: rtl/fwrisc_csr_seq_if.sv
// Request/completion bundle between the core's CSR decode and fwrisc_csr_seq.
// The master offers one decoded Zicsr instruction; the slave reports done/illegal.
interface fwrisc_csr_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data;
    logic [4:0]  rd_idx;
    logic        done;
    logic        illegal;

    modport master (
        output req_valid, csr_addr, csr_op, rs1_idx, rs1_data, rd_idx,
        input  req_ready, done, illegal
    );

    modport slave (
        input  req_valid, csr_addr, csr_op, rs1_idx, rs1_data, rd_idx,
        output req_ready, done, illegal
    );
endinterface

// File: rtl/fwrisc_csr_seq.sv
// Zicsr sequencer: maps CSR addresses to register-file slots and performs
// the read-modify-write plus old-value writeback to rd through the regfile.
module fwrisc_csr_seq #(
    parameter bit ENABLE_COUNTERS = 1'b1,
    parameter bit ENABLE_DEP      = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    fwrisc_csr_seq_if.slave     req,
    output logic                busy,
    output logic [5:0]          rb_raddr,
    input  logic [31:0]         rb_rdata,
    output logic [5:0]          rd_waddr,
    output logic [31:0]         rd_wdata,
    output logic                rd_wen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CSR,
        S_GPR,
        S_ERR
    } state_t;

    state_t      state, state_n;

    logic [5:0]  dec_slot;
    logic        dec_hit;
    logic        dec_ro;
    logic        wi;
    logic        ill;

    logic [5:0]  slot_q;
    logic [1:0]  op_q;
    logic [31:0] rs1_data_q;
    logic [4:0]  rd_idx_q;
    logic        wi_q;
    logic [31:0] old_q;
    logic [31:0] new_val;

    always_comb begin
        dec_slot = 6'd0;
        dec_hit  = 1'b0;
        dec_ro   = 1'b0;
        case (req.csr_addr)
            12'hF11, 12'hF12, 12'hF13, 12'hF14: begin
                dec_hit  = 1'b1;
                dec_ro   = 1'b1;
                dec_slot = {3'b100, req.csr_addr[2:0]};
            end
            12'h300, 12'h301, 12'h302, 12'h303,
            12'h304, 12'h305, 12'h306: begin
                dec_hit  = 1'b1;
                dec_slot = {3'b101, req.csr_addr[2:0]};
            end
            12'h340, 12'h341, 12'h342, 12'h343, 12'h344: begin
                dec_hit  = 1'b1;
                dec_ro   = (req.csr_addr == 12'h344);
                dec_slot = {3'b110, req.csr_addr[2:0]};
            end
            // Machine counters and their user read-only aliases share slots
            12'hB00, 12'hB80, 12'hB02, 12'hB82: begin
                dec_hit  = ENABLE_COUNTERS;
                dec_slot = {4'b1110, req.csr_addr[1], req.csr_addr[7]};
            end
            12'hC00, 12'hC80, 12'hC02, 12'hC82: begin
                dec_hit  = ENABLE_COUNTERS;
                dec_ro   = 1'b1;
                dec_slot = {4'b1110, req.csr_addr[1], req.csr_addr[7]};
            end
            12'h7C0, 12'h7C1: begin
                dec_hit  = ENABLE_DEP;
                dec_slot = {4'b1111, req.csr_addr[1:0]};
            end
            12'h7C2: begin
                dec_hit  = 1'b1;
                dec_slot = 6'h3E;
            end
            default: begin
                dec_hit  = 1'b0;
            end
        endcase
    end

    assign wi  = (req.csr_op == 2'b01) || (req.rs1_idx != 5'd0);
    assign ill = !dec_hit || (req.csr_op == 2'b00) || (wi && dec_ro);

    always_comb begin
        unique case (op_q)
            2'b10:   new_val = rb_rdata | rs1_data_q;
            2'b11:   new_val = rb_rdata & ~rs1_data_q;
            default: new_val = rs1_data_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            slot_q     <= 6'd0;
            op_q       <= 2'd0;
            rs1_data_q <= 32'd0;
            rd_idx_q   <= 5'd0;
            wi_q       <= 1'b0;
            old_q      <= 32'd0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && req.req_valid) begin
                slot_q     <= dec_slot;
                op_q       <= req.csr_op;
                rs1_data_q <= req.rs1_data;
                rd_idx_q   <= req.rd_idx;
                wi_q       <= wi;
            end
            if (state == S_CSR) begin
                old_q <= rb_rdata;
            end
        end
    end

    always_comb begin
        state_n       = state;
        req.req_ready = 1'b0;
        req.done      = 1'b0;
        req.illegal   = 1'b0;
        busy          = 1'b1;
        rb_raddr      = 6'd0;
        rd_waddr      = 6'd0;
        rd_wdata      = 32'd0;
        rd_wen        = 1'b0;
        unique case (state)
            S_IDLE: begin
                req.req_ready = 1'b1;
                busy          = 1'b0;
                if (req.req_valid) begin
                    state_n = ill ? S_ERR : S_RD;
                end
            end
            S_RD: begin
                rb_raddr = slot_q;
                state_n  = S_CSR;
            end
            S_CSR: begin
                if (wi_q) begin
                    rd_wen   = 1'b1;
                    rd_waddr = slot_q;
                    rd_wdata = new_val;
                end
                state_n = S_GPR;
            end
            S_GPR: begin
                if (rd_idx_q != 5'd0) begin
                    rd_wen   = 1'b1;
                    rd_waddr = {1'b0, rd_idx_q};
                    rd_wdata = old_q;
                end
                req.done = 1'b1;
                state_n  = S_IDLE;
            end
            S_ERR: begin
                req.done    = 1'b1;
                req.illegal = 1'b1;
                state_n     = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fwrisc_csr_seq.sv
// Scoreboard bench for fwrisc_csr_seq: a default instance and one with
// counters/DEP disabled, each backed by a small register-file model.
module tb_fwrisc_csr_seq;

    typedef struct {
        int          cyc;
        bit          is_done;
        bit          ill;
        logic [5:0]  addr;
        logic [31:0] data;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rf_load = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    ev_t  q0[$];
    ev_t  q1[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    fwrisc_csr_seq_if bus0();
    fwrisc_csr_seq_if bus1();

    logic        busy0, busy1;
    logic [5:0]  rb_raddr0, rb_raddr1;
    logic [31:0] rb_rdata0, rb_rdata1;
    logic [5:0]  rd_waddr0, rd_waddr1;
    logic [31:0] rd_wdata0, rd_wdata1;
    logic        rd_wen0, rd_wen1;
    logic [31:0] rf0 [64];
    logic [31:0] rf1 [64];

    fwrisc_csr_seq u_dut (
        .clock    (clock),
        .reset    (reset),
        .req      (bus0),
        .busy     (busy0),
        .rb_raddr (rb_raddr0),
        .rb_rdata (rb_rdata0),
        .rd_waddr (rd_waddr0),
        .rd_wdata (rd_wdata0),
        .rd_wen   (rd_wen0)
    );

    fwrisc_csr_seq #(
        .ENABLE_COUNTERS (1'b0),
        .ENABLE_DEP      (1'b0)
    ) u_dis (
        .clock    (clock),
        .reset    (reset),
        .req      (bus1),
        .busy     (busy1),
        .rb_raddr (rb_raddr1),
        .rb_rdata (rb_rdata1),
        .rd_waddr (rd_waddr1),
        .rd_wdata (rd_wdata1),
        .rd_wen   (rd_wen1)
    );

    function automatic logic [31:0] init_val(int i);
        case (i)
            'h30:    return 32'h1234_5678;
            'h28:    return 32'h0000_0080;
            default: return 32'hA500_0000 + i;
        endcase
    endfunction

    always @(posedge clock) begin
        if (rf_load) begin
            for (int i = 0; i < 64; i++) rf0[i] <= init_val(i);
        end else if (rd_wen0) begin
            rf0[rd_waddr0] <= rd_wdata0;
        end
        rb_rdata0 <= rf0[rb_raddr0];
    end

    always @(posedge clock) begin
        if (rf_load) begin
            for (int i = 0; i < 64; i++) rf1[i] <= init_val(i);
        end else if (rd_wen1) begin
            rf1[rd_waddr1] <= rd_wdata1;
        end
        rb_rdata1 <= rf1[rb_raddr1];
    end

    function automatic bit pop(int d, output ev_t e);
        e = '{cyc: 0, is_done: 1'b0, ill: 1'b0, addr: 6'd0, data: 32'd0};
        if (d == 0) begin
            if (q0.size() == 0) return 1'b0;
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) return 1'b0;
            e = q1.pop_front();
        end
        return 1'b1;
    endfunction

    task automatic mon(int d, bit wen, logic [5:0] wa, logic [31:0] wd,
                       bit dn, bit il);
        ev_t e;
        if (wen) begin
            n_cmp++;
            if (!pop(d, e)) begin
                n_err++;
                $display("FAIL dut%0d unexpected_write cyc=%0d got %h<=%h",
                         d, cyc, wa, wd);
            end else if (e.is_done || e.cyc != cyc || e.addr !== wa
                         || e.data !== wd) begin
                n_err++;
                $display("FAIL dut%0d write cyc=%0d got %h<=%h exp cyc=%0d %h<=%h done=%0b",
                         d, cyc, wa, wd, e.cyc, e.addr, e.data, e.is_done);
            end
        end
        if (dn) begin
            n_cmp++;
            if (!pop(d, e)) begin
                n_err++;
                $display("FAIL dut%0d unexpected_done cyc=%0d ill=%0b", d, cyc, il);
            end else if (!e.is_done || e.cyc != cyc || e.ill != il) begin
                n_err++;
                $display("FAIL dut%0d done cyc=%0d ill=%0b exp cyc=%0d ill=%0b done=%0b",
                         d, cyc, il, e.cyc, e.ill, e.is_done);
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0, rd_wen0 === 1'b1, rd_waddr0, rd_wdata0,
            bus0.done === 1'b1, bus0.illegal === 1'b1);
        mon(1, rd_wen1 === 1'b1, rd_waddr1, rd_wdata1,
            bus1.done === 1'b1, bus1.illegal === 1'b1);
    end

    task automatic push(int d, int c, bit dn, bit il, logic [5:0] a,
                        logic [31:0] v);
        ev_t e;
        e = '{cyc: c, is_done: dn, ill: il, addr: a, data: v};
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive(int d, bit v, logic [11:0] a, logic [1:0] op,
                         logic [4:0] ri, logic [31:0] rdat, logic [4:0] rdi);
        if (d == 0) begin
            bus0.req_valid = v; bus0.csr_addr = a; bus0.csr_op = op;
            bus0.rs1_idx = ri; bus0.rs1_data = rdat; bus0.rd_idx = rdi;
        end else begin
            bus1.req_valid = v; bus1.csr_addr = a; bus1.csr_op = op;
            bus1.rs1_idx = ri; bus1.rs1_data = rdat; bus1.rd_idx = rdi;
        end
    endtask

    task automatic issue(int d, logic [11:0] a, logic [1:0] op, logic [4:0] ri,
                         logic [31:0] rdat, logic [4:0] rdi, output int t);
        bit rdy;
        drive(d, 1'b1, a, op, ri, rdat, rdi);
        t = -1;
        for (int k = 0; k < 50 && t < 0; k++) begin
            @(negedge clock);
            rdy = (d == 0) ? bus0.req_ready : bus1.req_ready;
            if (rdy) t = cyc;
            @(posedge clock);
            #1;
        end
        drive(d, 1'b0, 12'h000, 2'b00, 5'd0, 32'd0, 5'd0);
        if (t < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL dut%0d accept_timeout addr=%h got no ready required ready",
                     d, a);
        end
    endtask

    // Expected response of a legal request accepted at cycle t
    task automatic legal(int d, int t, bit wi, logic [5:0] slot,
                         logic [31:0] nv, logic [4:0] rdi, logic [31:0] old);
        if (wi) push(d, t + 2, 1'b0, 1'b0, slot, nv);
        if (rdi != 5'd0) push(d, t + 3, 1'b0, 1'b0, {1'b0, rdi}, old);
        push(d, t + 3, 1'b1, 1'b0, 6'd0, 32'd0);
    endtask

    task automatic bad(int d, int t);
        push(d, t + 1, 1'b1, 1'b1, 6'd0, 32'd0);
    endtask

    task automatic chk_idle(string name);
        n_cmp++;
        if (bus0.req_ready !== 1'b1 || busy0 !== 1'b0 || bus0.done !== 1'b0
            || bus0.illegal !== 1'b0 || rd_wen0 !== 1'b0 || rb_raddr0 !== 6'd0
            || rd_waddr0 !== 6'd0 || rd_wdata0 !== 32'd0) begin
            n_err++;
            $display("FAIL %s got rdy=%b busy=%b done=%b ill=%b wen=%b ra=%h wa=%h wd=%h required idle values",
                     name, bus0.req_ready, busy0, bus0.done, bus0.illegal,
                     rd_wen0, rb_raddr0, rd_waddr0, rd_wdata0);
        end
    endtask

    initial begin
        int t, t2;
        drive(0, 1'b0, 12'h000, 2'b00, 5'd0, 32'd0, 5'd0);
        drive(1, 1'b0, 12'h000, 2'b00, 5'd0, 32'd0, 5'd0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        rf_load = 1'b0;
        @(negedge clock);
        chk_idle("reset_state");
        @(posedge clock);
        #1;

        issue(0, 12'h340, 2'b01, 5'd1, 32'hDEAD_BEEF, 5'd5, t);
        legal(0, t, 1'b1, 6'h30, 32'hDEAD_BEEF, 5'd5, 32'h1234_5678);
        issue(0, 12'h300, 2'b10, 5'd3, 32'h0000_0008, 5'd6, t);
        legal(0, t, 1'b1, 6'h28, 32'h0000_0088, 5'd6, 32'h0000_0080);
        issue(0, 12'hF11, 2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, t);
        legal(0, t, 1'b0, 6'h21, 32'd0, 5'd0, 32'd0);
        issue(0, 12'hF11, 2'b01, 5'd2, 32'h1, 5'd3, t);
        bad(0, t);
        issue(0, 12'h7FF, 2'b01, 5'd2, 32'h1, 5'd3, t);
        bad(0, t);
        issue(0, 12'h340, 2'b00, 5'd2, 32'h1, 5'd3, t);
        bad(0, t);
        issue(0, 12'h341, 2'b11, 5'd2, 32'hF000_0001, 5'd1, t);
        legal(0, t, 1'b1, 6'h31, 32'h0500_0030, 5'd1, 32'hA500_0031);
        issue(0, 12'hC00, 2'b10, 5'd0, 32'hFFFF_FFFF, 5'd2, t);
        legal(0, t, 1'b0, 6'h38, 32'd0, 5'd2, 32'hA500_0038);
        issue(0, 12'hC00, 2'b10, 5'd4, 32'h1, 5'd2, t);
        bad(0, t);
        issue(0, 12'h344, 2'b01, 5'd0, 32'h1, 5'd2, t);
        bad(0, t);
        issue(0, 12'hB82, 2'b10, 5'd0, 32'h0, 5'd3, t);
        legal(0, t, 1'b0, 6'h3B, 32'd0, 5'd3, 32'hA500_003B);
        issue(0, 12'h7C1, 2'b10, 5'd1, 32'h0000_0100, 5'd4, t);
        legal(0, t, 1'b1, 6'h3D, 32'hA500_013D, 5'd4, 32'hA500_003D);
        issue(0, 12'h7C2, 2'b01, 5'd1, 32'h0000_0001, 5'd0, t);
        legal(0, t, 1'b1, 6'h3E, 32'h0000_0001, 5'd0, 32'd0);

        issue(0, 12'h340, 2'b01, 5'd1, 32'h1111_1111, 5'd8, t);
        legal(0, t, 1'b1, 6'h30, 32'h1111_1111, 5'd8, 32'hDEAD_BEEF);
        issue(0, 12'h340, 2'b01, 5'd1, 32'h2222_2222, 5'd9, t2);
        legal(0, t2, 1'b1, 6'h30, 32'h2222_2222, 5'd9, 32'h1111_1111);
        n_cmp++;
        if (t2 != t + 4) begin
            n_err++;
            $display("FAIL back_to_back accept got cyc %0d required %0d", t2, t + 4);
        end

        // Reset lands while the read-only RS sits in the CSR state
        issue(0, 12'h300, 2'b10, 5'd0, 32'hFFFF_FFFF, 5'd7, t);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk_idle("reset_mid_csr");
        @(posedge clock);
        #1;
        issue(0, 12'h300, 2'b10, 5'd0, 32'hFFFF_FFFF, 5'd7, t);
        legal(0, t, 1'b0, 6'h28, 32'd0, 5'd7, 32'h0000_0088);

        issue(1, 12'hB00, 2'b10, 5'd0, 32'h0, 5'd3, t);
        bad(1, t);
        issue(1, 12'hC80, 2'b10, 5'd0, 32'h0, 5'd3, t);
        bad(1, t);
        issue(1, 12'h7C0, 2'b10, 5'd0, 32'h0, 5'd3, t);
        bad(1, t);
        issue(1, 12'h7C2, 2'b01, 5'd5, 32'h0000_00AA, 5'd4, t);
        legal(1, t, 1'b1, 6'h3E, 32'h0000_00AA, 5'd4, 32'hA500_003E);

        repeat (8) @(posedge clock);
        #1;
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL drain pending got %0d/%0d required 0/0",
                     q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
